// File: rtl/div_if.sv
// Issue/result bundle between the EX-stage pipeline and the iterative divider.
// The pipeline drives through the master modport, and div_unit uses the slave modport.
interface div_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [4:0]      rd;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;
    logic [4:0]      done_rd;

    modport master (
        output start, funct3, rs1_val, rs2_val, rd, flush,
        input  busy, stall, done, result, done_rd
    );

    modport slave (
        input  start, funct3, rs1_val, rs2_val, rd, flush,
        output busy, stall, done, result, done_rd
    );
endinterface

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with sign fix-up.
// Defining DIV_EARLY_OUT_EN lets zero-divisor, overflow and |a|<|b| ops finish without iterating.
module div_unit #(
    parameter int XLEN = 32
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);
    localparam int CW = $clog2(XLEN);
`ifdef DIV_EARLY_OUT_EN
    localparam bit EARLY_OUT = 1'b1;
`else
    localparam bit EARLY_OUT = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic            done_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      done_rd_q;

    logic [XLEN-1:0] quo, rem, divisor_mag, dividend;
    logic [4:0]      rd_q;
    logic            is_rem_q, neg_q_q, neg_r_q, div_zero_q, ovf_q;

    logic            in_signed, in_rem, in_div_zero, in_ovf, in_small, in_neg_q, in_neg_r;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            accept, early;

    logic [XLEN:0]   rem_sh, rem_diff;
    logic            take;
    logic [XLEN-1:0] rem_next, quo_next;

    function automatic logic [XLEN-1:0] fix_result(
        input logic [XLEN-1:0] q, r, a,
        input logic is_rem, neg_q, neg_r, div_zero, ovf
    );
        logic [XLEN-1:0] sq, sr;
        sq = neg_q ? -q : q;
        sr = neg_r ? -r : r;
        if (div_zero) return is_rem ? a : '1;
        if (ovf)      return is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        return is_rem ? sr : sq;
    endfunction

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        in_signed = 1'b0;
        in_rem    = 1'b0;
        case (bus.funct3)
            3'b100:  in_signed = 1'b1;
            3'b110:  begin in_signed = 1'b1; in_rem = 1'b1; end
            3'b111:  in_rem = 1'b1;
            default: ;
        endcase
    end

    assign abs_a       = (in_signed && bus.rs1_val[XLEN-1]) ? -bus.rs1_val : bus.rs1_val;
    assign abs_b       = (in_signed && bus.rs2_val[XLEN-1]) ? -bus.rs2_val : bus.rs2_val;
    assign in_neg_q    = in_signed && (bus.rs1_val[XLEN-1] ^ bus.rs2_val[XLEN-1]);
    assign in_neg_r    = in_signed && bus.rs1_val[XLEN-1];
    assign in_div_zero = (bus.rs2_val == '0);
    assign in_ovf      = in_signed && (bus.rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (bus.rs2_val == '1);
    assign in_small    = (abs_a < abs_b);
    assign accept      = (state == IDLE) && bus.start && !bus.flush;
    assign early       = EARLY_OUT && (in_div_zero || in_ovf || in_small);

    // Restoring step: a borrow out of the (XLEN+1)-bit subtraction means the divisor did not fit.
    assign rem_sh   = {rem, quo[XLEN-1]};
    assign rem_diff = rem_sh - {1'b0, divisor_mag};
    assign take     = !rem_diff[XLEN];
    assign rem_next = take ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_next = {quo[XLEN-2:0], take};

    // NOTE: datapath registers carry no reset; they are always loaded on accept before being used.
    always_ff @(posedge clk) begin
        if (accept) begin
            quo         <= abs_a;
            rem         <= '0;
            divisor_mag <= abs_b;
            dividend    <= bus.rs1_val;
            rd_q        <= bus.rd;
            is_rem_q    <= in_rem;
            neg_q_q     <= in_neg_q;
            neg_r_q     <= in_neg_r;
            div_zero_q  <= in_div_zero;
            ovf_q       <= in_ovf;
        end else if (state == CALC) begin
            quo <= quo_next;
            rem <= rem_next;
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            done_rd_q <= '0;
        end else if (bus.flush) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (early) begin
                            state     <= DONE;
                            done_q    <= 1'b1;
                            result_q  <= fix_result('0, abs_a, bus.rs1_val, in_rem, in_neg_q,
                                                    in_neg_r, in_div_zero, in_ovf);
                            done_rd_q <= bus.rd;
                        end else begin
                            state <= CALC;
                            count <= CW'(XLEN-1);
                        end
                    end
                end
                CALC: begin
                    if (count == '0) begin
                        state     <= DONE;
                        done_q    <= 1'b1;
                        result_q  <= fix_result(quo_next, rem_next, dividend, is_rem_q, neg_q_q,
                                                neg_r_q, div_zero_q, ovf_q);
                        done_rd_q <= rd_q;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy    = (state != IDLE);
    assign bus.stall   = (bus.start && (state == IDLE) && !bus.flush) || (state == CALC);
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.done_rd = done_rd_q;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: an arithmetic reference model is checked every cycle,
// and hand-computed vectors are checked at each completion.
module tb_div_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

`ifdef DIV_EARLY_OUT_EN
    localparam bit EO = 1'b1;
`else
    localparam bit EO = 1'b0;
`endif

    div_if #(.XLEN(32)) bus ();
    div_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit          m_valid = 1'b0;
    bit          pend    = 1'b0;
    int          done_cyc;
    logic [31:0] pend_res, last_res;
    logic [4:0]  pend_rd, last_rd;
    bit          done_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit is_signed_op(input logic [2:0] f3);
        return (f3 == 3'b100) || (f3 == 3'b110);
    endfunction

    function automatic bit is_rem_op(input logic [2:0] f3);
        return (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    function automatic logic [31:0] model_res(input logic [2:0] f3, input logic [31:0] a, b);
        longint sa, sb, q, r;
        if (b == 0) return is_rem_op(f3) ? a : 32'hFFFF_FFFF;
        if (is_signed_op(f3)) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return is_rem_op(f3) ? r[31:0] : q[31:0];
    endfunction

    function automatic bit model_early(input logic [2:0] f3, input logic [31:0] a, b);
        logic [31:0] ma, mb;
        bit s;
        s  = is_signed_op(f3);
        ma = (s && a[31]) ? 32'd0 - a : a;
        mb = (s && b[31]) ? 32'd0 - b : b;
        return (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) || (ma < mb);
    endfunction

    // Reference model: advances at each rising edge using the inputs of the cycle that just ended.
    always @(posedge clk) begin
        if (reset) begin
            m_valid  = 1'b1;
            pend     = 1'b0;
            last_res = '0;
            last_rd  = '0;
        end else if (m_valid) begin
            if (pend && cyc == done_cyc) begin
                last_res = pend_res;
                last_rd  = pend_rd;
                pend     = 1'b0;
            end else if (bus.flush) begin
                pend = 1'b0;
            end else if (bus.start && !pend) begin
                pend     = 1'b1;
                done_cyc = cyc + ((EO && model_early(bus.funct3, bus.rs1_val, bus.rs2_val)) ? 1 : 33);
                pend_res = model_res(bus.funct3, bus.rs1_val, bus.rs2_val);
                pend_rd  = bus.rd;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            done_e = pend && (cyc == done_cyc);
            check("busy",    32'(bus.busy), 32'(pend));
            check("done",    32'(bus.done), 32'(done_e));
            check("stall",   32'(bus.stall),
                  32'((bus.start && !pend && !bus.flush) || (pend && cyc < done_cyc)));
            check("result",  bus.result, done_e ? pend_res : last_res);
            check("done_rd", 32'(bus.done_rd), 32'(done_e ? pend_rd : last_rd));
        end
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, b, input logic [4:0] rd);
        @(posedge clk); #1;
        bus.start   = 1'b1;
        bus.funct3  = f3;
        bus.rs1_val = a;
        bus.rs2_val = b;
        bus.rd      = rd;
    endtask

    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a, b,
                          input logic [4:0] rd, input logic [31:0] exp, input bit early_case);
        int n;
        bit seen;
        seen = 1'b0;
        issue(f3, a, b, rd);
        n = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, " done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({name, " latency"}, 32'(cyc - n), (EO && early_case) ? 32'd1 : 32'd33);
            check({name, " value"},   bus.result, exp);
            check({name, " rd"},      32'(bus.done_rd), 32'(rd));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses;
        logic [31:0] got;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.funct3  = 3'b000;
        bus.rs1_val = '0;
        bus.rs2_val = '0;
        bus.rd      = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset busy",   32'(bus.busy), 32'd0);
        check("reset done",   32'(bus.done), 32'd0);
        check("reset result", bus.result, 32'd0);

        run_op("divu_100_7",   3'b101, 32'd100,        32'd7,          5'd5,  32'd14,         1'b0);
        run_op("remu_100_7",   3'b111, 32'd100,        32'd7,          5'd6,  32'd2,          1'b0);
        run_op("div_m7_2",     3'b100, 32'hFFFF_FFF9,  32'd2,          5'd7,  32'hFFFF_FFFD,  1'b0);
        run_op("rem_m7_2",     3'b110, 32'hFFFF_FFF9,  32'd2,          5'd8,  32'hFFFF_FFFF,  1'b0);
        run_op("rem_7_m2",     3'b110, 32'd7,          32'hFFFF_FFFE,  5'd9,  32'd1,          1'b0);
        run_op("div_5_0",      3'b100, 32'd5,          32'd0,          5'd10, 32'hFFFF_FFFF,  1'b1);
        run_op("remu_5_0",     3'b111, 32'd5,          32'd0,          5'd11, 32'd5,          1'b1);
        run_op("div_ovf",      3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  1'b1);
        run_op("rem_ovf",      3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1'b1);
        run_op("divu_small",   3'b101, 32'd3,          32'd10,         5'd14, 32'd0,          1'b1);
        run_op("rem_small",    3'b110, 32'hFFFF_FFFD,  32'd10,         5'd15, 32'hFFFF_FFFD,  1'b1);
        run_op("f3_000_divu",  3'b000, 32'd100,        32'd7,          5'd16, 32'd14,         1'b0);
        run_op("divu_max_1",   3'b101, 32'hFFFF_FFFF,  32'd1,          5'd0,  32'hFFFF_FFFF,  1'b0);

        // Flush during the 10th CALC cycle: no completion may follow.
        issue(3'b101, 32'd1000, 32'd3, 5'd4);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 bus.flush = 1'b1;
        @(posedge clk); #1 bus.flush = 1'b0;
        @(negedge clk);
        check("flush busy", 32'(bus.busy), 32'd0);
        pulses = 0;
        for (int i = 0; i < 35; i++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("flush no_done", 32'(pulses), 32'd0);
        run_op("divu_9_3", 3'b101, 32'd9, 32'd3, 5'd2, 32'd3, 1'b0);

        // Start with flush in the same cycle is dropped.
        issue(3'b101, 32'd50, 32'd5, 5'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk);
        check("flush_start busy", 32'(bus.busy), 32'd0);

        // A second start while busy is ignored; exactly one completion.
        issue(3'b101, 32'd100, 32'd7, 5'd3);
        n = cyc;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        bus.start   = 1'b1;
        bus.rs1_val = 32'd50;
        bus.rs2_val = 32'd5;
        bus.rd      = 5'd9;
        @(posedge clk); #1 bus.start = 1'b0;
        pulses = 0;
        got    = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                pulses++;
                got = bus.result;
                check("ignore latency", 32'(cyc - n), 32'd33);
            end
        end
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore value",  got, 32'd14);

        // Reset in the middle of CALC clears every output.
        issue(3'b101, 32'd100, 32'd7, 5'd21);
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        check("rst busy",    32'(bus.busy),    32'd0);
        check("rst done",    32'(bus.done),    32'd0);
        check("rst stall",   32'(bus.stall),   32'd0);
        check("rst result",  bus.result,       32'd0);
        check("rst done_rd", 32'(bus.done_rd), 32'd0);
        repeat (40) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
